// File: rtl/pyjamask96_sched.sv
// Two-requester round-robin scheduler and byte sequencer feeding one pyjamask96 core.
// Optional abort timer in WAIT/CAPTURE is compiled in with `define PYJ_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | arbiter open, reqN_ready may assert
// LOAD    | 16 cycles of key/block bytes on core_load, MSB first
// START   | single-cycle core_start pulse
// WAIT    | waiting for the first core output byte
// CAPTURE | collecting the remaining output bytes
// RESP    | result presented until rsp_ready
module pyjamask96_sched #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [95:0]  req0_block,
   input  logic [127:0] req0_key,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [95:0]  req1_block,
   input  logic [127:0] req1_key,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [95:0]  rsp_data,
   output logic         rsp_err,
   output logic         core_load,
   output logic         core_start,
   output logic [7:0]   core_byte,
   output logic [7:0]   core_kbyte,
   input  logic         core_valid,
   input  logic [7:0]   core_byte_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_RESP
   } state_t;

   state_t         state;
   logic           last;
   logic           grant;
   logic [3:0]     cnt;
   logic [95:0]    blk_q;
   logic [127:0]   key_q;
   logic [95:0]    sel_blk;
   logic [127:0]   sel_key;

   // Contention goes to the requester that did not win last time.
   assign grant      = (req0_valid && req1_valid) ? ~last : req1_valid;
   assign req0_ready = reset_n && (state == S_IDLE) && req0_valid && !grant;
   assign req1_ready = reset_n && (state == S_IDLE) && req1_valid && grant;
   assign sel_blk    = grant ? req1_block : req0_block;
   assign sel_key    = grant ? req1_key   : req0_key;

`ifdef PYJ_SCHED_TIMEOUT_EN
   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;
   assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
   assign rsp_err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         last       <= 1'b1;
         cnt        <= '0;
         blk_q      <= '0;
         key_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         core_load  <= 1'b0;
         core_start <= 1'b0;
         core_byte  <= '0;
         core_kbyte <= '0;
`ifdef PYJ_SCHED_TIMEOUT_EN
         to_cnt     <= '0;
         rsp_err    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_ready || req1_ready) begin
                  // Byte 0 goes out straight from the request; the rest shift from the copies.
                  core_load  <= 1'b1;
                  core_byte  <= sel_blk[95:88];
                  core_kbyte <= sel_key[127:120];
                  blk_q      <= {sel_blk[87:0], 8'h00};
                  key_q      <= {sel_key[119:0], 8'h00};
                  rsp_id     <= grant;
                  last       <= grant;
                  rsp_data   <= '0;
                  cnt        <= '0;
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (cnt == 4'd15) begin
                  core_load  <= 1'b0;
                  core_byte  <= '0;
                  core_kbyte <= '0;
                  core_start <= 1'b1;
                  state      <= S_START;
               end else begin
                  cnt        <= cnt + 4'd1;
                  core_byte  <= blk_q[95:88];
                  core_kbyte <= key_q[127:120];
                  blk_q      <= {blk_q[87:0], 8'h00};
                  key_q      <= {key_q[119:0], 8'h00};
               end
            end
            S_START: begin
               core_start <= 1'b0;
               cnt        <= '0;
`ifdef PYJ_SCHED_TIMEOUT_EN
               to_cnt     <= '0;
`endif
               state      <= S_WAIT;
            end
            S_WAIT, S_CAPTURE: begin
`ifdef PYJ_SCHED_TIMEOUT_EN
               to_cnt <= to_cnt + 1'b1;
               if (to_hit) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else
`endif
               if (core_valid) begin
                  rsp_data <= {rsp_data[87:0], core_byte_o};
                  if (cnt == 4'd11) begin
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     cnt   <= cnt + 4'd1;
                     state <= S_CAPTURE;
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
`ifdef PYJ_SCHED_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pyjamask96_sched.sv
// Directed bench for pyjamask96_sched: load sequencing, capture, arbitration, response hold, reset.
module tb_pyjamask96_sched;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [95:0]  req0_block = '0, req1_block = '0;
   logic [127:0] req0_key = '0, req1_key = '0;
   logic         rsp_valid, rsp_id, rsp_err;
   logic         rsp_ready = 1'b0;
   logic [95:0]  rsp_data;
   logic         core_load, core_start;
   logic [7:0]   core_byte, core_kbyte;
   logic         core_valid = 1'b0;
   logic [7:0]   core_byte_o = '0;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   pyjamask96_sched #(.TIMEOUT_CYCLES(32), .CNT_W(13)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_key(req1_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .core_load(core_load), .core_start(core_start), .core_byte(core_byte),
      .core_kbyte(core_kbyte), .core_valid(core_valid), .core_byte_o(core_byte_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one complete job and checks every core-side and response-side cycle.
   task automatic run_job(input logic v0, input logic v1, input logic exp_id,
                          input logic [95:0] b0, input logic [127:0] k0,
                          input logic [95:0] b1, input logic [127:0] k1,
                          input int gap, input int hold, input logic [7:0] base);
      logic [95:0]  blk_e;
      logic [127:0] key_e;
      logic [95:0]  rsp_e;
      logic [7:0]   eb, ek;
      req0_valid = v0; req0_block = b0; req0_key = k0;
      req1_valid = v1; req1_block = b1; req1_key = k1;
      blk_e = exp_id ? b1 : b0;
      key_e = exp_id ? k1 : k0;
      #1;
      chk_cnt++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01))
         $display("FAIL grant: ready={r1,r0}=%b expected id %0d", {req1_ready, req0_ready}, exp_id);
      else pass_cnt++;
      @(posedge clk); #1;
      if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         eb = (k < 12) ? blk_e[95-8*k -: 8] : 8'h00;
         ek = key_e[127-8*k -: 8];
         chk_cnt++;
         if ({core_load, core_start, core_byte, core_kbyte} !== {2'b10, eb, ek})
            $display("FAIL load[%0d]: load=%b start=%b byte=%h kbyte=%h expected 1 0 %h %h",
                     k, core_load, core_start, core_byte, core_kbyte, eb, ek);
         else pass_cnt++;
         chk_cnt++;
         if ({req1_ready, req0_ready} !== 2'b00)
            $display("FAIL busy_ready[%0d]: ready=%b expected 00", k, {req1_ready, req0_ready});
         else pass_cnt++;
         tick();
      end
      chk_cnt++;
      if ({core_load, core_start} !== 2'b01)
         $display("FAIL start: load=%b start=%b expected 0 1", core_load, core_start);
      else pass_cnt++;
      // Stray core byte during START must not be captured.
      core_valid = 1'b1; core_byte_o = 8'hEE;
      tick();
      core_valid = 1'b0;
      chk_cnt++;
      if (core_start !== 1'b0) $display("FAIL start_pulse: start=%b expected 0", core_start);
      else pass_cnt++;
      rsp_e = '0;
      for (int i = 0; i < 12; i++) begin
         core_valid = 1'b1;
         core_byte_o = 8'(base + i);
         rsp_e = {rsp_e[87:0], 8'(base + i)};
         tick();
         core_byte_o = 8'h55;
         core_valid = (i == 11);
         chk_cnt++;
         if (rsp_valid !== (i == 11))
            $display("FAIL rsp_timing[%0d]: rsp_valid=%b expected %b", i, rsp_valid, i == 11);
         else pass_cnt++;
         if (i < 11) repeat (gap) tick();
      end
      for (int h = 0; h < hold; h++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         chk_cnt++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data, req1_ready, req0_ready} !== {1'b1, exp_id, 1'b0, rsp_e, 2'b00})
            $display("FAIL rsp_hold[%0d]: valid=%b id=%b err=%b data=%h ready=%b expected 1 %b 0 %h 00",
                     h, rsp_valid, rsp_id, rsp_err, rsp_data, {req1_ready, req0_ready}, exp_id, rsp_e);
         else pass_cnt++;
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; core_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL rsp_clear: rsp_valid=%b expected 0", rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req0_valid = 1'b1;
      tick(); tick();
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, core_load, core_start, core_byte, core_kbyte,
           req0_ready, req1_ready} !== '0)
         $display("FAIL reset_outputs: valid=%b load=%b start=%b byte=%h kbyte=%h data=%h r0=%b",
                  rsp_valid, core_load, core_start, core_byte, core_kbyte, rsp_data, req0_ready);
      else pass_cnt++;
      req0_valid = 1'b0;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      run_job(1'b1, 1'b0, 1'b0, 96'h000102030405060708090A0B, 128'h000102030405060708090A0B0C0D0E0F,
              '0, '0, 0, 1, 8'hA0);
   endtask

   task automatic test_gaps();
      run_job(1'b0, 1'b1, 1'b1, '0, '0, 96'hFEDCBA987654321011223344,
              128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 3, 1, 8'h30);
   endtask

   task automatic test_hold();
      run_job(1'b1, 1'b0, 1'b0, 96'hDEADBEEFCAFEF00D12345678, 128'h8899AABBCCDDEEFF0011223344556677,
              '0, '0, 0, 10, 8'hC0);
   endtask

   task automatic test_round_robin();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int j = 0; j < 4; j++)
         run_job(1'b1, 1'b1, 1'(j % 2), {12{8'(8'h10 + j)}}, {16{8'(8'h20 + j)}},
                 {12{8'(8'h60 + j)}}, {16{8'(8'h70 + j)}}, 0, 1, 8'(8'h80 + 16 * j));
   endtask

   task automatic test_reset_mid_load();
      req1_valid = 1'b1; req1_block = {12{8'h99}}; req1_key = {16{8'h77}};
      tick();
      tick(); tick(); tick();
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({core_load, core_start, core_byte, core_kbyte, rsp_valid, req1_ready} !== '0)
         $display("FAIL reset_mid_load: load=%b start=%b byte=%h kbyte=%h rsp_valid=%b r1=%b",
                  core_load, core_start, core_byte, core_kbyte, rsp_valid, req1_ready);
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      req0_valid = 1'b1;
      #1;
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'b01)
         $display("FAIL reset_idle_grant: ready=%b expected 01", {req1_ready, req0_ready});
      else pass_cnt++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (30) tick();
      chk_cnt++;
      if ({rsp_valid, core_load, core_start} !== 3'b000)
         $display("FAIL reset_no_resp: rsp_valid=%b load=%b start=%b expected 000",
                  rsp_valid, core_load, core_start);
      else pass_cnt++;
   endtask

`ifdef PYJ_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int waited;
      req0_valid = 1'b1; req0_block = {12{8'h5A}}; req0_key = {16{8'hA5}};
      tick();
      req0_valid = 1'b0;
      waited = 0;
      while (rsp_valid !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      chk_cnt++;
      if ({rsp_valid, rsp_err, rsp_id, rsp_data} !== {3'b110, 96'h0})
         $display("FAIL timeout: valid=%b err=%b id=%b data=%h after %0d cycles expected 1 1 0 0",
                  rsp_valid, rsp_err, rsp_id, rsp_data, waited);
      else pass_cnt++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_cnt++;
      if ({rsp_valid, rsp_err} !== 2'b00)
         $display("FAIL timeout_clear: valid=%b err=%b expected 00", rsp_valid, rsp_err);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_gaps();
      test_hold();
      test_round_robin();
`ifdef PYJ_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
